alu: RTL and testbench

//  - Registered 4-operation ALU: ADD, SUB, bitwise INV of A, reduction-OR of B.
//  - One operation is accepted per cycle under a valid qualifier.
//  - Result and flags appear one clock later.
//  - Leaf datapath block used by control/sequencer logic; no backpressure.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_datapath.sv | 55 +++++
 rtl/alu.sv | 70 +++++++
 tb/tb_alu.sv | 135 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encoding shared by the ALU, its sequencer and the testbench
package alu_pkg;

  typedef enum logic [1:0] {
    ADD    = 2'b00,
    SUB    = 2'b01,
    INV    = 2'b10,
    RED_OR = 2'b11
  } opcode_e;

  localparam logic [1:0] OPC_ADD    = 2'b00;
  localparam logic [1:0] OPC_SUB    = 2'b01;
  localparam logic [1:0] OPC_INV    = 2'b10;
  localparam logic [1:0] OPC_RED_OR = 2'b11;

endpackage

// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - combinational ALU core; ALU_SAT_EN selects saturating ADD/SUB
// Produces the value to be registered plus the carry/borrow flag.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  opcode_e          opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] next_result,
  output logic             next_carry
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = a - b;
  assign borrow = (a < b);

  always_comb begin
    next_result = '0;
    next_carry  = 1'b0;
    unique case (opcode)
      ADD: begin
        next_carry  = sum[WIDTH];
`ifdef ALU_SAT_EN
        next_result = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        next_result = sum[WIDTH-1:0];
`endif
      end
      SUB: begin
        next_carry  = borrow;
`ifdef ALU_SAT_EN
        next_result = borrow ? '0 : diff;
`else
        next_result = diff;
`endif
      end
      INV: begin
        next_result = ~a;
      end
      RED_OR: begin
        next_result = WIDTH'(|b);
      end
      default: begin
        next_result = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered 4-op ALU, one op per cycle, latency 1; ALU_SAT_EN enables saturation
// Qualifies inputs with in_valid, registers result/flags and derives the zero flag.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  opcode_e          opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH-1:0] dp_result;
  logic             dp_carry;

  logic             valid_q,  valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q,  carry_d;
  logic             zero_q,   zero_d;

  alu_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .opcode      (opcode),
    .a           (A),
    .b           (B),
    .next_result (dp_result),
    .next_carry  (dp_carry)
  );

  // Datapath outputs are only sampled under in_valid, so idle-cycle X never reaches the flops.
  always_comb begin
    valid_d  = in_valid;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    if (in_valid) begin
      result_d = dp_result;
      carry_d  = dp_carry;
      zero_d   = (dp_result == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu (WIDTH=2 and WIDTH=8), honours ALU_SAT_EN
module tb_alu;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;

  logic       in_valid;
  opcode_e    opcode;
  logic [1:0] a, b;
  logic       out_valid;
  logic [1:0] result;
  logic       carry, zero;

  logic       in_valid8;
  opcode_e    opcode8;
  logic [7:0] a8, b8;
  logic       out_valid8;
  logic [7:0] result8;
  logic       carry8, zero8;

  int total = 0;
  int bad   = 0;

  alu #(.WIDTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode),
    .A(a), .B(b), .out_valid(out_valid), .result(result), .carry(carry), .zero(zero)
  );

  alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .opcode(opcode8),
    .A(a8), .B(b8), .out_valid(out_valid8), .result(result8), .carry(carry8), .zero(zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input opcode_e op, input logic [1:0] va, input logic [1:0] vb);
    in_valid = 1'b1;
    opcode   = op;
    a        = va;
    b        = vb;
    tick();
  endtask

  task automatic expect2(input string tag, input logic ov, input logic [1:0] r,
                         input logic c, input logic z);
    check({tag, ".valid"},  32'(out_valid), 32'(ov));
    check({tag, ".result"}, 32'(result),    32'(r));
    check({tag, ".carry"},  32'(carry),     32'(c));
    check({tag, ".zero"},   32'(zero),      32'(z));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; opcode = ADD; a = '0; b = '0;
    in_valid8 = 1'b0; opcode8 = ADD; a8 = '0; b8 = '0;
    tick();
    tick();
    expect2("reset", 1'b0, 2'b00, 1'b0, 1'b0);
    check("reset8.valid", 32'(out_valid8), 32'd0);
    rst_n = 1'b1;

    issue(ADD, 2'b10, 2'b01);
    expect2("add_10_01", 1'b1, 2'b11, 1'b0, 1'b0);
    issue(SUB, 2'b10, 2'b01);
    expect2("sub_10_01", 1'b1, 2'b01, 1'b0, 1'b0);
    issue(INV, 2'b10, 2'b01);
    expect2("inv_10", 1'b1, 2'b01, 1'b0, 1'b0);
    issue(RED_OR, 2'b10, 2'b01);
    expect2("redor_01", 1'b1, 2'b01, 1'b0, 1'b0);

`ifdef ALU_SAT_EN
    issue(ADD, 2'b11, 2'b01);
    expect2("add_ovf", 1'b1, 2'b11, 1'b1, 1'b0);
    issue(SUB, 2'b01, 2'b10);
    expect2("sub_brw", 1'b1, 2'b00, 1'b1, 1'b1);
`else
    issue(ADD, 2'b11, 2'b01);
    expect2("add_ovf", 1'b1, 2'b00, 1'b1, 1'b1);
    issue(SUB, 2'b01, 2'b10);
    expect2("sub_brw", 1'b1, 2'b11, 1'b1, 1'b0);
`endif
    issue(RED_OR, 2'b11, 2'b00);
    expect2("redor_00", 1'b1, 2'b00, 1'b0, 1'b1);

    in_valid = 1'b0;
    a = 2'bxx; b = 2'bxx; opcode = INV;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect2($sformatf("idle%0d", i), 1'b0, 2'b00, 1'b0, 1'b1);
    end

    issue(ADD, 2'b10, 2'b01);
    expect2("pre_rst", 1'b1, 2'b11, 1'b0, 1'b0);
    rst_n = 1'b0;
    issue(ADD, 2'b11, 2'b01);
    expect2("rst_vs_valid", 1'b0, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    issue(ADD, 2'b01, 2'b01);
    expect2("post_rst", 1'b1, 2'b10, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    check("post_rst_drop", 32'(out_valid), 32'd0);

    in_valid8 = 1'b1; opcode8 = ADD; a8 = 8'hA5; b8 = 8'h5A;
    tick();
    check("w8_add.valid",  32'(out_valid8), 32'd1);
    check("w8_add.result", 32'(result8),    32'hFF);
    check("w8_add.carry",  32'(carry8),     32'd0);
    opcode8 = INV; a8 = 8'hA5;
    tick();
    check("w8_inv.result", 32'(result8),    32'h5A);
    check("w8_inv.zero",   32'(zero8),      32'd0);
    in_valid8 = 1'b0;
    tick();
    check("w8_idle.valid", 32'(out_valid8), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
